// File: rtl/parking_pkg.sv
// Shared types and seven-segment glyphs for the car-park gate controller.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        STOP          = 3'd4
    } state_t;

    // Active-low segments, bit6=g .. bit0=a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;

endpackage

// File: rtl/parking_hex_decode.sv
// Maps the controller state onto the two status digits; purely combinational.
module parking_hex_decode
    import parking_pkg::*;
(
    input  state_t     state_i,
    output logic [6:0] hex_1_o,
    output logic [6:0] hex_2_o
);

    // Glyph pair per state; unknown encodings show blank like IDLE
    always_comb begin
        hex_1_o = SEG_BLANK;
        hex_2_o = SEG_BLANK;
        case (state_i)
            WAIT_PASSWORD: begin hex_1_o = SEG_E; hex_2_o = SEG_N; end
            WRONG_PASS:    begin hex_1_o = SEG_E; hex_2_o = SEG_E; end
            RIGHT_PASS:    begin hex_1_o = SEG_6; hex_2_o = SEG_0; end
            STOP:          begin hex_1_o = SEG_S; hex_2_o = SEG_P; end
            default:       begin hex_1_o = SEG_BLANK; hex_2_o = SEG_BLANK; end
        endcase
    end

endmodule

// File: rtl/parking_system.sv
// Single-lane car-park gate controller: password check on arrival, LEDs and two 7-seg digits.
module parking_system
    import parking_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [1:0]  PASS_1      = 2'b01,
    parameter logic [1:0]  PASS_2      = 2'b10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_entrance,
    input  logic       sensor_exit,
    input  logic [1:0] password_1,
    input  logic [1:0] password_2,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic [6:0] HEX_1,
    output logic [6:0] HEX_2
);

    localparam int unsigned   CntW    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            blink_q, blink_d;
    logic            pass_ok;

    assign pass_ok = (password_1 == PASS_1) && (password_2 == PASS_2);

    // Next-state, wait counter and blink phase
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        blink_d = ~blink_q;
        case (state_q)
            IDLE: begin
                if (sensor_entrance) state_d = WAIT_PASSWORD;
            end
            WAIT_PASSWORD: begin
                // Counter runs only here; the password matters on the last wait clock alone
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q >= CntLast) begin
                    state_d = pass_ok ? RIGHT_PASS : WRONG_PASS;
                end
            end
            WRONG_PASS: begin
                if (pass_ok) state_d = RIGHT_PASS;
            end
            RIGHT_PASS: begin
                if (sensor_entrance && sensor_exit) state_d = STOP;
                else if (sensor_exit)               state_d = IDLE;
            end
            STOP: begin
                if (pass_ok) state_d = RIGHT_PASS;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, cleared immediately on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    // LED drive straight from registered state and blink phase
    always_comb begin
        GREEN_LED = 1'b0;
        RED_LED   = 1'b0;
        case (state_q)
            WAIT_PASSWORD: RED_LED   = 1'b1;
            WRONG_PASS:    RED_LED   = blink_q;
            RIGHT_PASS:    GREEN_LED = blink_q;
            STOP:          RED_LED   = blink_q;
            default: begin
                GREEN_LED = 1'b0;
                RED_LED   = 1'b0;
            end
        endcase
    end

    parking_hex_decode u_hex (
        .state_i (state_q),
        .hex_1_o (HEX_1),
        .hex_2_o (HEX_2)
    );

endmodule

// File: tb/tb_parking_system.sv
// Scoreboard bench for parking_system: a reference model predicts outputs per clock.
module tb_parking_system;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor_entrance = 1'b0;
    logic       sensor_exit = 1'b0;
    logic [1:0] password_1 = 2'b00;
    logic [1:0] password_2 = 2'b00;
    logic       GREEN_LED, RED_LED;
    logic [6:0] HEX_1, HEX_2;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];

    // Reference model state: 0 idle, 1 wait, 2 wrong, 3 right, 4 stop
    int m_state = 0;
    int m_cnt   = 0;
    bit m_blink = 1'b0;

    always #5 clk = ~clk;

    parking_system dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .password_1      (password_1),
        .password_2      (password_2),
        .GREEN_LED       (GREEN_LED),
        .RED_LED         (RED_LED),
        .HEX_1           (HEX_1),
        .HEX_2           (HEX_2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {G,R,H1,H2}=%b_%b_%b_%b expected %b_%b_%b_%b", tag,
                     got[15], got[14], got[13:7], got[6:0],
                     exp[15], exp[14], exp[13:7], exp[6:0]);
        end
    endtask

    function automatic logic [15:0] model_out();
        logic g, r;
        logic [6:0] h1, h2;
        g = 1'b0; r = 1'b0; h1 = 7'h7F; h2 = 7'h7F;
        case (m_state)
            1: begin r = 1'b1;    h1 = 7'b0000110; h2 = 7'b0101011; end
            2: begin r = m_blink; h1 = 7'b0000110; h2 = 7'b0000110; end
            3: begin g = m_blink; h1 = 7'b0000010; h2 = 7'b1000000; end
            4: begin r = m_blink; h1 = 7'b0010010; h2 = 7'b0001100; end
            default: ;
        endcase
        return {g, r, h1, h2};
    endfunction

    function automatic logic [15:0] dut_out();
        return {GREEN_LED, RED_LED, HEX_1, HEX_2};
    endfunction

    // Advance model by one rising edge using current inputs, then compare after the edge
    task automatic step(input string tag);
        bit ok;
        int nxt;
        ok  = (password_1 == 2'b01) && (password_2 == 2'b10);
        nxt = m_state;
        case (m_state)
            0: if (sensor_entrance) nxt = 1;
            1: if (m_cnt >= 3) nxt = ok ? 3 : 2;
            2: if (ok) nxt = 3;
            3: if (sensor_entrance && sensor_exit) nxt = 4; else if (sensor_exit) nxt = 0;
            4: if (ok) nxt = 3;
            default: nxt = 0;
        endcase
        m_cnt   = (m_state == 1) ? m_cnt + 1 : 0;
        m_state = nxt;
        m_blink = ~m_blink;
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        check(tag, dut_out(), exp_q.pop_front());
    endtask

    task automatic set_in(input bit ent, input bit ex, input logic [1:0] p1, input logic [1:0] p2);
        sensor_entrance = ent;
        sensor_exit     = ex;
        password_1      = p1;
        password_2      = p2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held 20 ns
        #12;
        exp_q.push_back(16'h3FFF);
        check("reset_hold", dut_out(), exp_q.pop_front());
        #8 reset_n = 1'b1;
        #1 check("reset_rel", dut_out(), 16'h3FFF);
        step("idle0");

        // 2: correct password -> four wait clocks -> right
        set_in(1, 0, 2'b01, 2'b10);
        step("wait1");
        set_in(0, 0, 2'b01, 2'b10);
        for (int i = 2; i <= 4; i++) step($sformatf("wait%0d", i));
        step("right_enter");
        for (int i = 0; i < 3; i++) step($sformatf("right_blink%0d", i));

        // 3: exit alone leaves for idle
        set_in(0, 1, 2'b01, 2'b10);
        step("exit_idle");
        set_in(0, 0, 2'b01, 2'b10);
        step("idle_hold");

        // 4: wrong password -> wrong; fix -> right
        set_in(1, 0, 2'b10, 2'b01);
        step("wwait1");
        set_in(0, 0, 2'b10, 2'b01);
        for (int i = 2; i <= 4; i++) step($sformatf("wwait%0d", i));
        step("wrong_enter");
        step("wrong_blink0");
        step("wrong_blink1");
        set_in(0, 1, 2'b10, 2'b01);
        step("wrong_exit_ign");
        set_in(0, 0, 2'b01, 2'b10);
        step("wrong_fix");

        // 5: entrance+exit in right -> stop; 00/00 holds; correct -> right
        set_in(1, 1, 2'b01, 2'b10);
        step("stop_enter");
        set_in(0, 0, 2'b00, 2'b00);
        step("stop_hold0");
        set_in(0, 1, 2'b00, 2'b00);
        step("stop_exit_ign");
        set_in(0, 0, 2'b01, 2'b10);
        step("stop_fix");
        set_in(0, 1, 2'b01, 2'b10);
        step("exit_idle2");

        // 6: exit and password churn in idle change nothing
        set_in(0, 1, 2'b11, 2'b00);
        step("idle_exit");
        set_in(0, 0, 2'b01, 2'b10);
        step("idle_pw");

        // Password only matters on the deciding edge: right until last, then wrong
        set_in(1, 0, 2'b01, 2'b10);
        step("late_wait1");
        set_in(0, 0, 2'b01, 2'b10);
        step("late_wait2");
        step("late_wait3");
        step("late_wait4");
        set_in(0, 0, 2'b11, 2'b11);
        step("late_wrong");
        // and wrong until last, then right
        set_in(0, 0, 2'b01, 2'b10);
        step("late_fix");
        set_in(0, 1, 2'b00, 2'b00);
        step("late_exit");
        set_in(1, 0, 2'b00, 2'b00);
        step("late2_wait1");
        set_in(0, 0, 2'b00, 2'b00);
        step("late2_wait2");
        step("late2_wait3");
        set_in(0, 0, 2'b01, 2'b10);
        step("late2_wait4");
        step("late2_right");

        // Async reset mid-run, away from any edge
        set_in(1, 0, 2'b10, 2'b10);
        step("pre_rst");
        #2 reset_n = 1'b0;
        #1 check("async_rst", dut_out(), 16'h3FFF);
        m_state = 0; m_cnt = 0; m_blink = 1'b0;
        @(posedge clk);
        #1 check("rst_hold_edge", dut_out(), 16'h3FFF);
        #2 reset_n = 1'b1;
        set_in(0, 0, 2'b00, 2'b00);
        step("post_rst_idle");
        set_in(1, 0, 2'b00, 2'b00);
        step("post_rst_wait");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
